// File: rtl/display_scan_ctrl.sv
// Seven-segment scan controller: digit select, active-low anodes with
// per-slot dead-time, and slot/frame pulses, all registered on one edge.
module display_scan_ctrl #(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned N_DIGITS     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic [3:0]          sel,
  output logic [N_DIGITS-1:0] an,
  output logic                tick,
  output logic                frame
);

  localparam int unsigned         CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]       CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [3:0]          SEL_MAX  = 4'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_LSB   = N_DIGITS'(1);

  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [3:0]          sel_nxt;
  logic [N_DIGITS-1:0] an_nxt;
  logic                adv;
  logic                wrap;
  logic                blank;

  assign adv  = en && (cnt == CNT_MAX);
  assign wrap = (sel == SEL_MAX);

  // Dead-time looks at the upcoming count so the anodes switch with sel.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank = 1'b0;
  end else begin : g_blank
    assign blank = (32'(cnt_nxt) < BLANK_CYCLES);
  end

  always_comb begin
    cnt_nxt = cnt;
    sel_nxt = sel;
    if (en) begin
      if (adv) begin
        cnt_nxt = '0;
        sel_nxt = wrap ? '0 : sel + 4'd1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_comb begin
    an_nxt = '1;
    if (en && !blank) begin
      an_nxt = ~(AN_LSB << sel_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      sel   <= '0;
      an    <= '1;
      tick  <= 1'b0;
      frame <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      sel   <= sel_nxt;
      an    <= an_nxt;
      tick  <= adv;
      frame <= adv && wrap;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: table-driven main configuration plus
// no-dead-time and single-digit configurations, checked via a scoreboard.
module tb_display_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut 0: CLK_DIV=4 BLANK=1 N=5; dut 1: BLANK=0; dut 2: CLK_DIV=2 N=1
  logic       rst_m = 1'b1, en_m = 1'b0;
  logic [3:0] sel_m;
  logic [4:0] an_m;
  logic       tick_m, frame_m;

  logic       rst_n = 1'b1, en_n = 1'b0;
  logic [3:0] sel_n;
  logic [4:0] an_n;
  logic       tick_n, frame_n;

  logic       rst_d = 1'b1, en_d = 1'b0;
  logic [3:0] sel_d;
  logic [0:0] an_d;
  logic       tick_d, frame_d;

  display_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(1), .N_DIGITS(5)) u_main (
    .clk(clk), .reset(rst_m), .en(en_m),
    .sel(sel_m), .an(an_m), .tick(tick_m), .frame(frame_m)
  );

  display_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(0), .N_DIGITS(5)) u_noblank (
    .clk(clk), .reset(rst_n), .en(en_n),
    .sel(sel_n), .an(an_n), .tick(tick_n), .frame(frame_n)
  );

  display_scan_ctrl #(.CLK_DIV(2), .BLANK_CYCLES(1), .N_DIGITS(1)) u_degen (
    .clk(clk), .reset(rst_d), .en(en_d),
    .sel(sel_d), .an(an_d), .tick(tick_d), .frame(frame_d)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] sel;
    logic [4:0] an;
    logic       tick;
    logic       frame;
  } vec_t;

  typedef struct {
    int         dut;
    int         idx;
    logic [3:0] sel;
    logic [4:0] an;
    logic       tick;
    logic       frame;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r, input logic e, input logic [3:0] s,
                     input logic [4:0] a, input logic t, input logic f);
    vec_t v;
    v.rst = r; v.en = e; v.sel = s; v.an = a; v.tick = t; v.frame = f;
    vecs.push_back(v);
  endtask

  task automatic addn(input int unsigned n, input logic r, input logic e,
                      input logic [3:0] s, input logic [4:0] a,
                      input logic t, input logic f);
    for (int unsigned i = 0; i < n; i++) add(r, e, s, a, t, f);
  endtask

  task automatic cmp(input string nm, input int dut, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d step %0d: got %0h expected %0h", nm, dut, idx, act, exp);
    end
  endtask

  task automatic check_front();
    exp_t       x;
    logic [3:0] s;
    logic [4:0] a;
    logic       t, f;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    x = sb.pop_front();
    case (x.dut)
      0:       begin s = sel_m; a = an_m;          t = tick_m; f = frame_m; end
      1:       begin s = sel_n; a = an_n;          t = tick_n; f = frame_n; end
      default: begin s = sel_d; a = {4'b0, an_d};  t = tick_d; f = frame_d; end
    endcase
    cmp("sel",   x.dut, x.idx, 8'(s), 8'(x.sel));
    cmp("an",    x.dut, x.idx, 8'(a), 8'(x.an));
    cmp("tick",  x.dut, x.idx, 8'(t), 8'(x.tick));
    cmp("frame", x.dut, x.idx, 8'(f), 8'(x.frame));
  endtask

  // Drive one edge's inputs, queue its expectation, then check just after the edge.
  task automatic step(input int dut, input logic r, input logic e, input exp_t x);
    @(negedge clk);
    case (dut)
      0:       begin rst_m = r; en_m = e; end
      1:       begin rst_n = r; en_n = e; end
      default: begin rst_d = r; en_d = e; end
    endcase
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t x;

    // Reset, full scan, enable drop, reset mid-scan, en low at slot end
    addn(3, 1, 1, 0, 5'b11111, 0, 0);
    addn(3, 0, 1, 0, 5'b11110, 0, 0);
    add (   0, 1, 1, 5'b11111, 1, 0);
    addn(3, 0, 1, 1, 5'b11101, 0, 0);
    add (   0, 1, 2, 5'b11111, 1, 0);
    addn(3, 0, 1, 2, 5'b11011, 0, 0);
    add (   0, 1, 3, 5'b11111, 1, 0);
    addn(3, 0, 1, 3, 5'b10111, 0, 0);
    add (   0, 1, 4, 5'b11111, 1, 0);
    addn(3, 0, 1, 4, 5'b01111, 0, 0);
    add (   0, 1, 0, 5'b11111, 1, 1);
    addn(3, 0, 1, 0, 5'b11110, 0, 0);
    add (   0, 1, 1, 5'b11111, 1, 0);
    addn(3, 0, 1, 1, 5'b11101, 0, 0);
    add (   0, 1, 2, 5'b11111, 1, 0);
    addn(3, 0, 1, 2, 5'b11011, 0, 0);
    add (   0, 1, 3, 5'b11111, 1, 0);
    addn(2, 0, 1, 3, 5'b10111, 0, 0);
    addn(5, 0, 0, 3, 5'b11111, 0, 0);
    add (   0, 1, 3, 5'b10111, 0, 0);
    add (   0, 1, 4, 5'b11111, 1, 0);
    addn(3, 0, 1, 4, 5'b01111, 0, 0);
    add (   1, 1, 0, 5'b11111, 0, 0);
    addn(3, 0, 1, 0, 5'b11110, 0, 0);
    add (   0, 0, 0, 5'b11111, 0, 0);
    add (   0, 1, 1, 5'b11111, 1, 0);

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      x.dut = 0; x.idx = int'(i);
      x.sel = vecs[i].sel; x.an = vecs[i].an;
      x.tick = vecs[i].tick; x.frame = vecs[i].frame;
      step(0, vecs[i].rst, vecs[i].en, x);
    end
    @(negedge clk); rst_m = 1'b1; en_m = 1'b0;

    // No dead-time: exactly one anode low from the first enabled edge
    for (int unsigned k = 0; k < 26; k++) begin
      x.dut = 1; x.idx = int'(k);
      if (k < 2) begin
        x.sel = 0; x.an = 5'b11111; x.tick = 0; x.frame = 0;
        step(1, 1'b1, 1'b1, x);
      end else begin
        x.sel   = 4'(((k - 1) / 4) % 5);
        x.an    = ~(5'b00001 << x.sel);
        x.tick  = ((k - 1) % 4) == 0;
        x.frame = ((k - 1) % 20) == 0;
        step(1, 1'b0, 1'b1, x);
        cmp("onehot_low", 1, int'(k), 8'($countones(an_n)), 8'd4);
      end
    end
    @(negedge clk); rst_n = 1'b1; en_n = 1'b0;

    // Single digit, two-cycle slot
    for (int unsigned k = 0; k < 10; k++) begin
      x.dut = 2; x.idx = int'(k); x.sel = 0;
      if (k < 2) begin
        x.an = 5'b00001; x.tick = 0; x.frame = 0;
        step(2, 1'b1, 1'b1, x);
      end else begin
        x.tick  = ((k - 1) % 2) == 0;
        x.frame = x.tick;
        x.an    = x.tick ? 5'b00001 : 5'b00000;
        step(2, 1'b0, 1'b1, x);
      end
    end

    cmp("sb_drained", 0, 0, 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
